// File: rtl/fp_pkg.sv
// Shared floating-point add-path definitions: widths, exponent limit, FSM states and result flags.
// Imported by both the alignment front end and the post-normaliser.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic zero;
  } flags_t;

endpackage

// File: rtl/fp_post_normalizer.sv
// Iterative post-normaliser for the FP add path: fixes carry-out with one right shift, removes
// leading zeros one left shift per cycle, and flags overflow, underflow and zero results.
module fp_post_normalizer #(
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W:0]   out_mant,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_zero,
  output logic              busy
);

  localparam logic [EXP_W-1:0] ExpMax = {EXP_W{1'b1}};

  fp_pkg::state_e   state_q, state_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [MANT_W+1:0] m_q, m_d;
  logic [EXP_W-1:0]  oexp_q, oexp_d;
  logic [MANT_W:0]   omant_q, omant_d;
  fp_pkg::flags_t   flags_q, flags_d;
  logic [EXP_W-1:0]  e_inc;

  assign e_inc = e_q + 1'b1;

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    m_d     = m_q;
    oexp_d  = oexp_q;
    omant_d = omant_q;
    flags_d = flags_q;
    unique case (state_q)
      fp_pkg::StIdle: begin
        if (in_valid) begin
          e_d     = in_exp;
          m_d     = in_mant;
          state_d = fp_pkg::StNorm;
        end
      end
      fp_pkg::StNorm: begin
        state_d = fp_pkg::StDone;
        if (m_q[MANT_W+1]) begin
          // Incrementing an all-ones exponent would wrap, so that case saturates too.
          if ((e_q == ExpMax) || (e_inc == ExpMax)) begin
            oexp_d      = ExpMax;
            omant_d     = '0;
            flags_d.ovf = 1'b1;
          end else begin
            oexp_d  = e_inc;
            omant_d = m_q[MANT_W+1:1];
          end
        end else if (m_q == '0) begin
          oexp_d       = '0;
          omant_d      = '0;
          flags_d.zero = 1'b1;
        end else if (m_q[MANT_W]) begin
          oexp_d  = e_q;
          omant_d = m_q[MANT_W:0];
        end else if (e_q == '0) begin
          oexp_d      = '0;
          omant_d     = m_q[MANT_W:0];
          flags_d.unf = 1'b1;
        end else begin
          m_d     = m_q << 1;
          e_d     = e_q - 1'b1;
          state_d = fp_pkg::StNorm;
        end
      end
      fp_pkg::StDone: begin
        if (out_ready) begin
          state_d = fp_pkg::StIdle;
          flags_d = '0;
        end
      end
      default: state_d = fp_pkg::StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= fp_pkg::StIdle;
      e_q     <= '0;
      m_q     <= '0;
      oexp_q  <= '0;
      omant_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      m_q     <= m_d;
      oexp_q  <= oexp_d;
      omant_q <= omant_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == fp_pkg::StIdle) && !rst;
  assign out_valid = (state_q == fp_pkg::StDone);
  assign busy      = (state_q != fp_pkg::StIdle);
  assign out_exp   = oexp_q;
  assign out_mant  = omant_q;
  assign out_ovf   = flags_q.ovf;
  assign out_unf   = flags_q.unf;
  assign out_zero  = flags_q.zero;

endmodule

// File: tb/tb_fp_post_normalizer.sv
// Directed bench for fp_post_normalizer: hand-computed vectors, latency, backpressure and reset.
module tb_fp_post_normalizer;

  localparam int unsigned EW = fp_pkg::EXP_W;
  localparam int unsigned MW = fp_pkg::MANT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_exp;
  logic [MW+1:0] in_mant;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exp;
  logic [MW:0]   out_mant;
  logic          out_ovf;
  logic          out_unf;
  logic          out_zero;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  fp_post_normalizer #(
    .EXP_W (EW),
    .MANT_W(MW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_exp  (out_exp),
    .out_mant (out_mant),
    .out_ovf  (out_ovf),
    .out_unf  (out_unf),
    .out_zero (out_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge; the design acts on the rising edge.
  task automatic run_op(input string tag, input logic [EW-1:0] ie, input logic [MW+1:0] im,
                        input int k, input logic [EW-1:0] ee, input logic [MW:0] em,
                        input logic [2:0] ef, input int hold);
    int n;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_exp   = ie;
    in_mant  = im;
    @(negedge clk);
    in_valid = 1'b0;
    in_exp   = '0;
    in_mant  = '0;
    check_eq({tag, ".busy0"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
      check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    end
    check_eq({tag, ".latency"}, 32'(n), 32'(k + 1));
    check_eq({tag, ".exp"}, 32'(out_exp), 32'(ee));
    check_eq({tag, ".mant"}, 32'(out_mant), 32'(em));
    check_eq({tag, ".flags"}, 32'({out_ovf, out_unf, out_zero}), 32'(ef));
    check_eq({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".hold_exp"}, 32'(out_exp), 32'(ee));
      check_eq({tag, ".hold_mant"}, 32'(out_mant), 32'(em));
      check_eq({tag, ".hold_flags"}, 32'({out_ovf, out_unf, out_zero}), 32'(ef));
      check_eq({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".flags_clr"}, 32'({out_ovf, out_unf, out_zero}), 32'd0);
    check_eq({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.out_exp", 32'(out_exp), 32'd0);
    check_eq("rst.out_mant", 32'(out_mant), 32'd0);
    check_eq("rst.flags", 32'({out_ovf, out_unf, out_zero}), 32'd0);
    check_eq("rst.in_ready", 32'(in_ready), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op("norm", 8'h80, 25'h0800000, 0, 8'h80, 24'h800000, 3'b000, 0);
    run_op("carry", 8'h7F, 25'h1800000, 0, 8'h80, 24'hC00000, 3'b000, 0);
    run_op("shift3", 8'h85, 25'h0100000, 3, 8'h82, 24'h800000, 3'b000, 0);
    run_op("unf", 8'h02, 25'h0000001, 2, 8'h00, 24'h000004, 3'b010, 0);
    run_op("ovf", 8'hFE, 25'h1000000, 0, fp_pkg::EXP_MAX, 24'h000000, 3'b100, 5);
    run_op("ovf_max", 8'hFF, 25'h1000000, 0, fp_pkg::EXP_MAX, 24'h000000, 3'b100, 0);
    run_op("zero", 8'h40, 25'h0000000, 0, 8'h00, 24'h000000, 3'b001, 0);
    run_op("unf_e0", 8'h00, 25'h0400000, 0, 8'h00, 24'h400000, 3'b010, 0);
    run_op("carry_fr", 8'h10, 25'h1FFFFFF, 0, 8'h11, 24'hFFFFFF, 3'b000, 0);

    // Reset while the three-shift operand is still normalising.
    @(negedge clk);
    in_valid = 1'b1;
    in_exp   = 8'h85;
    in_mant  = 25'h0100000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst.in_ready_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst.busy", 32'(busy), 32'd0);
    check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check_eq("midrst.no_output", 32'(seen), 32'd0);

    run_op("recover", 8'h85, 25'h0100000, 3, 8'h82, 24'h800000, 3'b000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
